// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends start, 8 data bits, odd parity and
// stop on device-generated clock edges, then checks the device acknowledge.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StStart,
        StShift,
        StStop,
        StAck,
        StWaitIdle
    } state_e;

    state_e            state_q, state_d;
    logic [InhW-1:0]   inh_cnt_q, inh_cnt_d;
    logic [ToW-1:0]    to_cnt_q, to_cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [8:0]        frame_q, frame_d;
    logic              ack_bit_q, ack_bit_d;
    logic              ack_ok_q, ack_ok_d;
    logic              clk_oe_q, clk_oe_d;
    logic              data_oe_q, data_oe_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              clk_meta_q, clk_sync_q, clk_prev_q;
    logic              data_meta_q, data_sync_q;
    logic              fall;
    logic              timed;
    logic              to_hit;

    assign fall   = clk_prev_q & ~clk_sync_q;
    assign timed  = (state_q != StIdle) && (state_q != StInhibit);
    assign to_hit = (to_cnt_q >= ToW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        ack_bit_d = ack_bit_q;
        ack_ok_d  = ack_ok_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        if (timed && (to_cnt_q != ToW'(TIMEOUT_CYCLES))) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && ready_q) begin
                    frame_d   = {~^cmd_data, cmd_data};
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = (INHIBIT_CYCLES <= 1);
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                inh_cnt_d = inh_cnt_q + 1'b1;
                if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = StStart;
                end else if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 2)) begin
                    // Data is pulled low only in the last inhibit cycle.
                    data_oe_d = 1'b1;
                end
            end
            StStart: begin
                if (fall) begin
                    data_oe_d = ~frame_q[0];
                    bit_cnt_d = 4'd1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (fall) begin
                    if (bit_cnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = StStop;
                    end else begin
                        data_oe_d = ~frame_q[bit_cnt_q];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (fall) begin
                    ack_bit_d = data_sync_q;
                    state_d   = StAck;
                end
            end
            StAck: begin
                ack_ok_d = ~ack_bit_q;
                state_d  = StWaitIdle;
            end
            StWaitIdle: begin
                if (clk_sync_q && data_sync_q) begin
                    done_d  = ack_ok_q;
                    error_d = ~ack_ok_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Timeout overrides any other outcome so done and error never coincide.
        if (timed && to_hit) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            error_d   = 1'b1;
            state_d   = StIdle;
        end

        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            inh_cnt_q   <= '0;
            to_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            ack_bit_q   <= 1'b1;
            ack_ok_q    <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            inh_cnt_q   <= inh_cnt_d;
            to_cnt_q    <= to_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            ack_bit_q   <= ack_bit_d;
            ack_ok_q    <= ack_ok_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            error_q     <= error_d;
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

    assign cmd_ready   = ready_q;
    assign busy        = (state_q != StIdle);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector PS/2 device model.
module tb_ps2_host_tx;

    localparam int Inh = 5000;
    localparam int To  = 3000;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, done, error;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int acc_cnt = 0;
    bit both_seen = 1'b0;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(Inh),
        .TIMEOUT_CYCLES(To)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (error) err_cnt <= err_cnt + 1;
        if (done && error) both_seen <= 1'b1;
    end

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic issue(input logic [7:0] b);
        int g;
        g = 0;
        @(negedge clk);
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        tests++;
        if (!cmd_ready) begin
            fails++;
            $display("FAIL issue_ready: cmd_ready=%b want 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Measures the inhibit phase and returns at the first negedge in START.
    task automatic frame_head(input string name);
        int g, inh, inh_d;
        bit last_d;
        g = 0; inh = 0; inh_d = 0; last_d = 1'b0;
        while (!ps2_clk_oe && g < 100) begin
            @(negedge clk);
            g++;
        end
        while (ps2_clk_oe && inh < Inh + 100) begin
            inh++;
            last_d = ps2_data_oe;
            if (ps2_data_oe) inh_d++;
            @(negedge clk);
        end
        tests++;
        if (inh != Inh) begin
            fails++;
            $display("FAIL %s inhibit_len: got %0d want %0d", name, inh, Inh);
        end
        tests++;
        if (inh_d != 1 || last_d !== 1'b1) begin
            fails++;
            $display("FAIL %s inhibit_data: cycles=%0d last=%b want 1/1", name, inh_d, last_d);
        end
        tests++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0)
        begin
            fails++;
            $display("FAIL %s start_lines: clk_oe=%b data_oe=%b busy=%b rdy=%b want 0/1/1/0",
                     name, ps2_clk_oe, ps2_data_oe, busy, cmd_ready);
        end
    endtask

    // Device clocks out the frame; abort_fall>0 stops with clock held low after that fall.
    task automatic device_clock(input bit ack, input int abort_fall, output logic [9:0] bits);
        bits = '0;
        for (int i = 1; i <= 11; i++) begin
            repeat (H) @(negedge clk);
            dev_clk = 1'b0;
            if (i == abort_fall) begin
                repeat (10) @(negedge clk);
                return;
            end
            repeat (H) @(negedge clk);
            if (i <= 10) bits[i-1] = ps2_data_in;
            dev_clk = 1'b1;
            if (i == 10 && ack) begin
                repeat (5) @(negedge clk);
                dev_data = 1'b0;
            end
        end
        if (ack) begin
            repeat (5) @(negedge clk);
            dev_data = 1'b1;
        end
    endtask

    // Returns on the negedge where done or error is observed.
    task automatic frame_tail(input logic [7:0] b, input bit par, input bit ack,
                              input string name);
        logic [9:0] bits;
        int g;
        device_clock(ack, 0, bits);
        tests++;
        if (bits[7:0] !== b) begin
            fails++;
            $display("FAIL %s data_bits: got %h want %h", name, bits[7:0], b);
        end
        tests++;
        if (bits[8] !== par || bits[9] !== 1'b1) begin
            fails++;
            $display("FAIL %s parity_stop: got %b/%b want %b/1", name, bits[8], bits[9], par);
        end
        g = 0;
        while (!(done || error) && g < 300) begin
            @(negedge clk);
            g++;
        end
        tests++;
        if (ack && (done !== 1'b1 || error !== 1'b0 || cmd_ready !== 1'b1)) begin
            fails++;
            $display("FAIL %s ack_outcome: done=%b err=%b rdy=%b want 1/0/1",
                     name, done, error, cmd_ready);
        end else if (!ack && (error !== 1'b1 || done !== 1'b0 || ps2_clk_oe !== 1'b0 ||
                              ps2_data_oe !== 1'b0)) begin
            fails++;
            $display("FAIL %s nack_outcome: done=%b err=%b oe=%b%b want 0/1/00",
                     name, done, error, ps2_clk_oe, ps2_data_oe);
        end
    endtask

    task automatic check_pulses(input int d0, input int e0, input int dw, input int ew,
                                input string name);
        repeat (3) @(negedge clk);
        tests++;
        if (done_cnt - d0 != dw || err_cnt - e0 != ew) begin
            fails++;
            $display("FAIL %s pulse_count: done=%0d err=%0d want %0d/%0d",
                     name, done_cnt - d0, err_cnt - e0, dw, ew);
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || cmd_ready !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: oe=%b%b rdy=%b busy=%b done=%b err=%b want all 0",
                     ps2_clk_oe, ps2_data_oe, cmd_ready, busy, done, error);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: rdy=%b busy=%b want 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_send(input logic [7:0] b, input bit par, input string name);
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        issue(b);
        frame_head(name);
        frame_tail(b, par, 1'b1, name);
        check_pulses(d0, e0, 1, 0, name);
    endtask

    task automatic test_nack();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        issue(8'h3C);
        frame_head("nack");
        frame_tail(8'h3C, 1'b1, 1'b0, "nack");
        check_pulses(d0, e0, 0, 1, "nack");
    endtask

    task automatic test_timeout();
        int d0, e0, k;
        d0 = done_cnt; e0 = err_cnt; k = 0;
        issue(8'hAB);
        frame_head("timeout");
        while (!error && k < To + 100) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k != To) begin
            fails++;
            $display("FAIL timeout_latency: got %0d want %0d", k, To);
        end
        tests++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            fails++;
            $display("FAIL timeout_release: oe=%b%b want 00", ps2_clk_oe, ps2_data_oe);
        end
        check_pulses(d0, e0, 0, 1, "timeout");
    endtask

    task automatic test_reset_mid();
        int d0, e0;
        logic [9:0] bits;
        d0 = done_cnt; e0 = err_cnt;
        issue(8'hF4);
        frame_head("rst_mid");
        device_clock(1'b1, 5, bits);
        reset_n = 1'b0;
        #1;
        tests++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_release: oe=%b%b busy=%b want 00/0",
                     ps2_clk_oe, ps2_data_oe, busy);
        end
        dev_clk = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check_pulses(d0, e0, 0, 0, "rst_mid");
        test_send(8'hF4, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        int a0, d0, e0;
        a0 = acc_cnt; d0 = done_cnt; e0 = err_cnt;
        @(negedge clk);
        cmd_data  = 8'hAA;
        cmd_valid = 1'b1;
        frame_head("b2b_1");
        cmd_data = 8'h55;
        tests++;
        if (acc_cnt - a0 != 1) begin
            fails++;
            $display("FAIL b2b_first_accept: accepted=%0d want 1", acc_cnt - a0);
        end
        frame_tail(8'hAA, 1'b1, 1'b1, "b2b_1");
        tests++;
        if (acc_cnt - a0 != 1) begin
            fails++;
            $display("FAIL b2b_busy_accept: accepted=%0d want 1", acc_cnt - a0);
        end
        frame_head("b2b_2");
        cmd_valid = 1'b0;
        tests++;
        if (acc_cnt - a0 != 2) begin
            fails++;
            $display("FAIL b2b_second_accept: accepted=%0d want 2", acc_cnt - a0);
        end
        frame_tail(8'h55, 1'b1, 1'b1, "b2b_2");
        check_pulses(d0, e0, 2, 0, "b2b");
        tests++;
        if (acc_cnt - a0 != 2) begin
            fails++;
            $display("FAIL b2b_total_accept: accepted=%0d want 2", acc_cnt - a0);
        end
    endtask

    initial begin
        test_reset();
        test_send(8'hED, 1'b1, "send_ed");
        test_send(8'h07, 1'b0, "send_07");
        test_nack();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        tests++;
        if (both_seen) begin
            fails++;
            $display("FAIL done_error_overlap: seen=%b want 0", both_seen);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, giving the clk cycles ps2 clock is held low before the start bit (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the clk cycles allowed from start-bit release to end of frame (20 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1 bit: system clock; the only clock, with all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset that is asynchronous and active-low.
REQ-005 SHALL have port cmd_data, input, 8 bits: byte to send to the device.
REQ-006 SHALL have port cmd_valid, input, 1 bit: the request is accepted when cmd_valid and cmd_ready are both high on a rising edge.
REQ-007 SHALL have port cmd_ready, output, 1 bit: high only in IDLE.
REQ-008 SHALL have port ps2_clk_in, input, 1 bit: raw PS/2 clock line, asynchronous to clk.
REQ-009 SHALL have port ps2_data_in, input, 1 bit: raw PS/2 data line, asynchronous to clk.
REQ-010 SHALL have port ps2_clk_oe, output, 1 bit: 1 drives the PS/2 clock low; 0 releases it.
REQ-011 SHALL have port ps2_data_oe, output, 1 bit: 1 drives the PS/2 data line low; 0 releases it.
REQ-012 SHALL have port busy, output, 1 bit: high whenever not in IDLE, so the receive buffer ignores frames.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when the device acks the frame.
REQ-014 SHALL have port error, output, 1 bit: one-cycle pulse on missing ack or timeout.

Function
REQ-015 SHALL synchronise ps2_clk_in and ps2_data_in through 2 flops each, and SHALL detect a falling edge as previous-synced=1 and synced=0.
REQ-016 SHALL use states IDLE, INHIBIT, START, SHIFT, STOP, ACK, WAIT_IDLE.
REQ-017 On handshake in IDLE, SHALL latch cmd_data, compute parity as the XOR of all 8 bits inverted (odd parity), and enter INHIBIT.
REQ-018 In INHIBIT, ps2_clk_oe SHALL be 1 for exactly INHIBIT_CYCLES cycles, and ps2_data_oe SHALL be 1 in the final cycle only.
REQ-019 In START, SHALL drive ps2_clk_oe=0 and ps2_data_oe=1 (start bit 0), clear the timeout counter, and wait for a falling edge.
REQ-020 On each falling edge in START/SHIFT, SHALL drive the next bit, with ps2_data_oe = inverse of the bit: data bits 0..7 LSB first, then parity, using a 4-bit bit counter.
REQ-021 On the falling edge after parity, SHALL release data (ps2_data_oe=0, stop bit) and enter STOP.
REQ-022 STOP SHALL wait for the next falling edge and then enter ACK, sampling synced data on that same edge.
REQ-023 In ACK, sampled data=0 SHALL mean acknowledged: go to WAIT_IDLE with ack_ok=1; sampled data=1 SHALL go to WAIT_IDLE with ack_ok=0.
REQ-024 WAIT_IDLE SHALL wait until synced clock and data are both 1, then pulse done if ack_ok=1 or error if ack_ok=0, and enter IDLE.
REQ-025 The timeout counter SHALL run from START through WAIT_IDLE and saturate.
REQ-026 On reaching TIMEOUT_CYCLES, SHALL release both lines, pulse error, and enter IDLE, in every state from START onward.
REQ-027 The frame SHALL ignore cmd_valid while busy; the request is neither queued nor dropped silently, it is simply not accepted.
REQ-028 ps2_clk_oe and ps2_data_oe SHALL be registered outputs, with no combinational path from inputs.
REQ-029 done and error SHALL never be high in the same cycle.

Reset
REQ-030 While reset_n=0, SHALL hold state=IDLE, ps2_clk_oe=0, ps2_data_oe=0, cmd_ready=0, busy=0, done=0, error=0, the counters at 0, and the synchronisers at 1.
REQ-031 cmd_ready SHALL become 1 on the first rising edge after reset_n deasserts.
REQ-032 Reset asserted mid-frame SHALL release both lines immediately (asynchronously) and abort the frame without a done or error pulse.

Verification
REQ-033 Send 0xED with a device model that acks -> clk held low 5000 cycles; bits 1,0,1,1,0,1,1,1; parity 1; stop; then one done pulse and cmd_ready=1.
REQ-034 Send 0x07 -> parity bit 0 on the line, and done pulses.
REQ-035 Device model that leaves data high at the ack clock -> one error pulse, no done, and both oe=0.
REQ-036 Device model that never clocks -> error pulses exactly TIMEOUT_CYCLES cycles after START entry, and both lines are released.
REQ-037 reset_n pulsed low during bit 4 -> both oe=0 within the reset, no done or error pulse, and the next 0xF4 command completes normally.
REQ-038 cmd_valid held high through a frame -> exactly one byte is accepted per frame, and a second byte is accepted only after returning to IDLE.
